keypad_scan_accum: RTL and testbench
====================================

Name: keypad_scan_accum

Overview:
Parametrised 4x4 matrix-keypad scanner, successor to the original column-rotating keypad scanner.
- Drives active-low columns and samples active-low rows on a divided scan tick.
- Debounces both press and release, and emits exactly one event per press.
- Accumulates decimal digits into a DIGITS-wide packed BCD value for the stopwatch/timer datapath; '*' clears the value, '#' confirms it.

Parameters:
CLK_DIV, 50000, clk cycles per scan tick (>=2)
DEBOUNCE_TICKS, 4, consecutive stable ticks required for press and release (>=1)
DIGITS, 4, BCD digits held in value (1..8)
REPEAT_DELAY, 50, ticks a digit is held before the first auto-repeat (AUTO_REPEAT_EN only)
REPEAT_RATE, 10, ticks between subsequent repeats (AUTO_REPEAT_EN only)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, asynchronous active-low reset
row_in  in  4  keypad rows, active-low, asynchronous to clk
col_out  out  4  column drive, exactly one bit low
key_valid  out  1  one-cycle pulse per accepted key event
key_code  out  4  code of last event: 0-9 digit, 10 '#', 11-14 'A'-'D', 15 '*'
value  out  4*DIGITS  packed BCD, newest digit in [3:0]
digit_cnt  out  $clog2(DIGITS+1)  digits entered since clear, saturates at DIGITS
enter  out  1  one-cycle pulse, coincident with key_valid for '#'

Behaviour:
- Reset values: col_out=4'b1110, key_valid=0, key_code=0, value=0, digit_cnt=0, enter=0; FSM=SCAN, tick counter=0.
- row_in passes through a 2-flop synchroniser before any use.
- tick: a one-cycle strobe every CLK_DIV clk cycles, from a free-running counter that wraps at CLK_DIV-1.
- Keymap (column index, row0..row3):
  - col0: 1, 4, 7, *
  - col1: 2, 5, 8, 0
  - col2: 3, 6, 9, #
  - col3: A, B, C, D
- FSM, evaluated on tick only:
  - SCAN: if the synchronised row has exactly one bit low, latch that pattern, clear the stable counter and go to DEBOUNCE; col_out holds. Otherwise col_out rotates left (1110 -> 1101 -> 1011 -> 0111 -> 1110). Zero or multiple low rows count as no key.
  - DEBOUNCE: row equal to the latch increments the stable counter; when it reaches DEBOUNCE_TICKS, emit the event and go to HELD. Any mismatch returns to SCAN with no event and no rotation on that tick.
  - HELD: column frozen. When row = 4'b1111, clear the counter and go to RELEASE. Any other change keeps HELD; there is no second event until release.
  - RELEASE: row 4'b1111 increments the counter; reaching DEBOUNCE_TICKS goes to SCAN and rotates once. Any low row resets the counter, stays in RELEASE and emits no event.
- Event: key_valid and key_code are registered 1 clk after the qualifying tick. value, digit_cnt and enter update in that same cycle.
- Digit d: value <= {value[4*DIGITS-5:0], d}; the oldest digit is dropped (equivalent to mod 10^DIGITS). digit_cnt increments and saturates at DIGITS.
- '*': value=0 and digit_cnt=0.
- '#': enter=1 for one cycle; value unchanged.
- 'A'-'D': event only; value unchanged.
- key_code holds its last value between events.
- rst_n asserted mid-debounce or mid-hold: immediate return to reset values; a key still held after reset is reported once, after a full DEBOUNCE_TICKS.

Optional Feature:
AUTO_REPEAT_EN
- Defined: in HELD with a digit key (0-9), re-emit the same event after REPEAT_DELAY ticks held, then every REPEAT_RATE ticks until release. Each repeat shifts value and updates digit_cnt as a normal press. '*', '#' and 'A'-'D' never repeat. The repeat counter clears on leaving HELD.
- Undefined: repeat logic and counters are absent; exactly one event per press.

Test Plan:
(bench uses CLK_DIV=4, DEBOUNCE_TICKS=3, DIGITS=4)
1. No key, rows 1111 for 32 clk -> col_out cycles 1110, 1101, 1011, 0111, changing every 4 clk; key_valid never asserted.
2. Clean press '5' (row1 low while col1 driven) held 10 ticks, then released -> single key_valid, key_code=5, value=16'h0005, digit_cnt=1, col_out frozen at 1101 while held.
3. Enter 1, 2, 3, 4, 5 -> value=16'h2345, digit_cnt=4 (saturated); then '*' -> value=0, digit_cnt=0, key_code=15.
4. Bounce: row toggles low/high every tick for 5 ticks, then steady low 3 ticks -> exactly one event; a 2-tick glitch alone produces no event.
5. '#' after value=16'h0042 -> enter and key_valid high in the same cycle, key_code=10, value stays 16'h0042; 'B' -> key_code=12, value unchanged.
6. rst_n low during DEBOUNCE with key '7' held -> all outputs return to reset values at once; after rst_n rises, one event with key_code=7. With AUTO_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, '9' held 12 ticks past acceptance -> 1 + 4 events, value=16'h9999.

Source files
------------

// File: rtl/keypad_scan_accum.sv
// keypad_scan_accum: 4x4 active-low keypad scanner with press/release debounce and packed-BCD digit accumulator.
//   clk, rst_n (async active-low), row_in[3:0] async active-low rows, col_out[3:0] one-low column drive,
//   key_valid one-cycle event strobe, key_code last event code, value packed BCD (newest in [3:0]),
//   digit_cnt digits since clear (saturating), enter one-cycle pulse on '#'.
//   Optional AUTO_REPEAT_EN: held digit keys re-fire after REPEAT_DELAY ticks, then every REPEAT_RATE ticks.
module keypad_scan_accum #(
  parameter int CLK_DIV        = 50000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int DIGITS         = 4,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [3:0]                   row_in,
  output logic [3:0]                   col_out,
  output logic                         key_valid,
  output logic [3:0]                   key_code,
  output logic [4*DIGITS-1:0]          value,
  output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
  output logic                         enter
);
  localparam int VW = 4*DIGITS;
  localparam int DW = $clog2(DIGITS+1);
  localparam int SW = $clog2(DEBOUNCE_TICKS+1);
  localparam int CW = $clog2(CLK_DIV);
  // code nibble at index {col, row}
  localparam logic [63:0] KEYMAP = 64'hEDCB_A963_0852_F741;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
  state_t          state;
  logic [3:0]      row_s1, row_s, row_lat, row_n, code, col_rot;
  logic [CW-1:0]   div_cnt;
  logic [SW-1:0]   stb_cnt, stb_next;
  logic [1:0]      col_idx, row_idx;
  logic            tick, one_low, deb_done, rep_fire, fire;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row_s1  <= 4'hF;
      row_s   <= 4'hF;
      div_cnt <= '0;
    end else begin
      row_s1  <= row_in;
      row_s   <= row_s1;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  always_comb begin
    tick     = div_cnt == CW'(CLK_DIV-1);
    row_n    = ~row_s;
    one_low  = (row_n != 4'd0) && ((row_n & (row_n - 4'd1)) == 4'd0);
    col_idx  = !col_out[0] ? 2'd0 : !col_out[1] ? 2'd1 : !col_out[2] ? 2'd2 : 2'd3;
    row_idx  = !row_lat[0] ? 2'd0 : !row_lat[1] ? 2'd1 : !row_lat[2] ? 2'd2 : 2'd3;
    code     = KEYMAP[{col_idx, row_idx, 2'b00} +: 4];
    col_rot  = {col_out[2:0], col_out[3]};
    stb_next = stb_cnt + 1'b1;
    deb_done = tick && state == DEBOUNCE && row_s == row_lat && stb_next == SW'(DEBOUNCE_TICKS);
    fire     = deb_done || rep_fire;
  end
`ifdef AUTO_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX+1);
  logic [RW-1:0] rep_cnt, rep_next;
  logic          rep_first, rep_hold;
  always_comb begin
    rep_hold = state == HELD && row_s != 4'hF && code < 4'd10;
    rep_next = rep_cnt + 1'b1;
    rep_fire = tick && rep_hold && rep_next == (rep_first ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY));
  end
  // counter restarts after each repeat; rep_first selects delay vs. rate
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else if (tick) begin
      rep_cnt   <= (!rep_hold || rep_fire) ? '0 : rep_next;
      rep_first <= rep_hold && (rep_fire || rep_first);
    end
`else
  assign rep_fire = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= SCAN;
      col_out   <= 4'b1110;
      row_lat   <= 4'hF;
      stb_cnt   <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      value     <= '0;
      digit_cnt <= '0;
      enter     <= 1'b0;
    end else begin
      key_valid <= fire;
      enter     <= fire && code == 4'd10;
      if (fire) begin
        key_code <= code;
        if (code == 4'd15) begin
          value     <= '0;
          digit_cnt <= '0;
        end else if (code < 4'd10) begin
          value     <= (value << 4) | VW'(code);
          digit_cnt <= digit_cnt == DW'(DIGITS) ? digit_cnt : digit_cnt + 1'b1;
        end
      end
      if (tick)
        unique case (state)
          SCAN:
            if (one_low) begin
              row_lat <= row_s;
              stb_cnt <= '0;
              state   <= DEBOUNCE;
            end else col_out <= col_rot;
          DEBOUNCE:
            if (row_s != row_lat) state <= SCAN;
            else if (stb_next == SW'(DEBOUNCE_TICKS)) state <= HELD;
            else stb_cnt <= stb_next;
          HELD:
            if (row_s == 4'hF) begin
              stb_cnt <= '0;
              state   <= RELEASE;
            end
          RELEASE:
            if (row_s != 4'hF) stb_cnt <= '0;
            else if (stb_next == SW'(DEBOUNCE_TICKS)) begin
              state   <= SCAN;
              col_out <= col_rot;
            end else stb_cnt <= stb_next;
        endcase
    end
endmodule

// File: tb/tb_keypad_scan_accum.sv
// tb_keypad_scan_accum: directed self-checking bench for keypad_scan_accum with a column-aware keypad model.
module tb_keypad_scan_accum;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row_in, col_out, key_code;
  logic        key_valid, enter;
  logic [15:0] value;
  logic [2:0]  digit_cnt;
  logic        kdown = 1'b0;
  logic [1:0]  kcol = 2'd0, krow = 2'd0;
  int          n_assert = 0, n_fail = 0;
  int          ev_cnt = 0, enter_cnt = 0, enter_kv = 0;
`ifdef AUTO_REPEAT_EN
  localparam int LONG = 4;
`else
  localparam int LONG = 10;
`endif
  keypad_scan_accum #(
    .CLK_DIV(4), .DEBOUNCE_TICKS(3), .DIGITS(4), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out), .key_valid(key_valid),
    .key_code(key_code), .value(value), .digit_cnt(digit_cnt), .enter(enter)
  );
  always #5 clk = ~clk;
  // a pressed key pulls its row low only while its column is driven
  assign row_in = (kdown && !col_out[kcol]) ? ~(4'b0001 << krow) : 4'b1111;
  always @(negedge clk) begin
    if (key_valid) ev_cnt++;
    if (enter) enter_cnt++;
    if (enter && key_valid) enter_kv++;
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_key(input int k);
    case (k)
      1: begin kcol = 0; krow = 0; end
      4: begin kcol = 0; krow = 1; end
      7: begin kcol = 0; krow = 2; end
      15: begin kcol = 0; krow = 3; end
      2: begin kcol = 1; krow = 0; end
      5: begin kcol = 1; krow = 1; end
      8: begin kcol = 1; krow = 2; end
      0: begin kcol = 1; krow = 3; end
      3: begin kcol = 2; krow = 0; end
      6: begin kcol = 2; krow = 1; end
      9: begin kcol = 2; krow = 2; end
      10: begin kcol = 2; krow = 3; end
      default: begin kcol = 3; krow = 2'(k - 11); end
    endcase
  endtask
  task automatic wait_event(input int e0);
    int t;
    t = 0;
    while (ev_cnt == e0 && t < 200) begin
      cyc(1);
      t++;
    end
    chk("event_arrived", ev_cnt, e0 + 1);
  endtask
  task automatic press(input int k, input int hold);
    int e0;
    logic [3:0] ec;
    e0 = ev_cnt;
    set_key(k);
    ec = ~(4'b0001 << kcol);
    kdown = 1'b1;
    wait_event(e0);
    chk("key_code", key_code, k);
    chk("col_frozen", col_out, ec);
    cyc(hold * 4);
    chk("col_held", col_out, ec);
    kdown = 1'b0;
    cyc(48);
    chk("single_event", ev_cnt, e0 + 1);
  endtask
  initial begin
    int e0, t;
    rst_n = 1'b0;
    cyc(3);
    chk("rst_col", col_out, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_value", value, 0);
    chk("rst_dcnt", digit_cnt, 0);
    chk("rst_enter", enter, 0);
    rst_n = 1'b1;
    cyc(1); chk("scan_c0", col_out, 4'b1110);
    cyc(2); chk("scan_c0_hold", col_out, 4'b1110);
    cyc(1); chk("scan_c1", col_out, 4'b1101);
    cyc(4); chk("scan_c2", col_out, 4'b1011);
    cyc(4); chk("scan_c3", col_out, 4'b0111);
    cyc(4); chk("scan_wrap", col_out, 4'b1110);
    cyc(16); chk("idle_no_event", ev_cnt, 0);
    press(5, LONG);
    chk("v5", value, 16'h0005);
    chk("d5", digit_cnt, 1);
    press(1, 2);
    press(2, 2);
    press(3, 2);
    chk("v5123", value, 16'h5123);
    chk("d_at4", digit_cnt, 4);
    press(4, 2);
    press(5, 2);
    chk("v2345", value, 16'h2345);
    chk("d_sat", digit_cnt, 4);
    press(15, 2);
    chk("clr_value", value, 0);
    chk("clr_dcnt", digit_cnt, 0);
    chk("clr_code", key_code, 15);
    e0 = ev_cnt;
    set_key(14);
    for (int i = 0; i < 5; i++) begin
      kdown = (i % 2 == 0);
      cyc(4);
    end
    kdown = 1'b1;
    wait_event(e0);
    chk("bounce_code", key_code, 14);
    kdown = 1'b0;
    cyc(48);
    chk("bounce_single", ev_cnt, e0 + 1);
    e0 = ev_cnt;
    kdown = 1'b1;
    cyc(8);
    kdown = 1'b0;
    cyc(48);
    chk("glitch_none", ev_cnt, e0);
    chk("bounce_value", value, 0);
    press(4, 2);
    press(2, 2);
    chk("v42", value, 16'h0042);
    press(10, 2);
    chk("hash_value", value, 16'h0042);
    chk("enter_cnt", enter_cnt, 1);
    chk("enter_with_valid", enter_kv, 1);
    press(12, 2);
    chk("b_value", value, 16'h0042);
    chk("b_no_enter", enter_cnt, 1);
    t = 0;
    while (col_out == 4'b1110 && t < 100) begin cyc(1); t++; end
    e0 = ev_cnt;
    set_key(7);
    kdown = 1'b1;
    t = 0;
    while (col_out != 4'b1110 && t < 100) begin cyc(1); t++; end
    chk("col0_reached", col_out, 4'b1110);
    cyc(8);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_col", col_out, 4'b1110);
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_code", key_code, 0);
    chk("mid_rst_value", value, 0);
    chk("mid_rst_dcnt", digit_cnt, 0);
    chk("mid_rst_enter", enter, 0);
    chk("mid_rst_no_event", ev_cnt, e0);
    cyc(3);
    rst_n = 1'b1;
    cyc(15);
    chk("post_rst_not_early", ev_cnt, e0);
    cyc(1);
    chk("post_rst_event", ev_cnt, e0 + 1);
    chk("post_rst_code", key_code, 7);
    chk("post_rst_value", value, 16'h0007);
    kdown = 1'b0;
    cyc(48);
    chk("post_rst_single", ev_cnt, e0 + 1);
`ifdef AUTO_REPEAT_EN
    e0 = ev_cnt;
    set_key(9);
    kdown = 1'b1;
    wait_event(e0);
    cyc(48);
    kdown = 1'b0;
    cyc(48);
    chk("repeat_events", ev_cnt, e0 + 5);
    chk("repeat_value", value, 16'h9999);
    chk("repeat_dcnt", digit_cnt, 4);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
